// File: rtl/spi_master.sv
// SPI mode-0 master: streams bytes out on MOSI (MSB first) inside one SSEL-low frame
// and returns the byte captured on MISO for every byte sent.
module spi_master #(
  parameter int DIV      = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int LENW     = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            done,
  output logic            SCK,
  output logic            MOSI,
  input  logic            MISO,
  output logic            SSEL
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_LOW, S_HIGH, S_HOLD, S_GUARD
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_limit;
  logic            w_cnt_last;
  logic [LENW-1:0] r_remain;
  logic [6:0]      r_tx_sh;
  logic [7:0]      r_rx_sh;
  logic [2:0]      r_bit;
  logic            r_sck;
  logic            r_mosi;
  logic            r_ssel;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_done;

  // One shared dwell counter; its terminal count depends on which timed state is active.
  always_comb begin
    w_limit = CW'(DIV);
    case (r_state)
      S_SETUP:         w_limit = CW'(CS_SETUP);
      S_HOLD, S_GUARD: w_limit = CW'(CS_HOLD);
      default:         w_limit = CW'(DIV);
    endcase
    w_cnt_last = (r_cnt == w_limit - CW'(1));
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && (len != '0)) w_state_next = S_SETUP;
      S_SETUP: if (w_cnt_last) w_state_next = S_LOAD;
      S_LOAD:  if (tx_valid) w_state_next = S_LOW;
      S_LOW:   if (w_cnt_last) w_state_next = S_HIGH;
      S_HIGH: begin
        if (w_cnt_last) begin
          if (r_bit != 3'd7)       w_state_next = S_LOW;
          else if (r_remain != '0) w_state_next = S_LOAD;
          else                     w_state_next = S_HOLD;
        end
      end
      S_HOLD:  if (w_cnt_last) w_state_next = S_GUARD;
      S_GUARD: if (w_cnt_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_remain   <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_bit      <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_ssel     <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= (w_state_next != r_state) ? '0 : r_cnt + CW'(1);
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            r_remain <= len;
            r_ssel   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (tx_valid) begin
            r_tx_sh  <= tx_data[6:0];
            r_mosi   <= tx_data[7];
            r_bit    <= '0;
            r_remain <= r_remain - LENW'(1);
          end
        end
        S_LOW: begin
          if (w_cnt_last) begin
            r_sck   <= 1'b1;
            r_rx_sh <= {r_rx_sh[6:0], MISO};
          end
        end
        S_HIGH: begin
          if (w_cnt_last) begin
            r_sck <= 1'b0;
            if (r_bit == 3'd7) begin
              r_mosi     <= 1'b0;
              r_rx_data  <= r_rx_sh;
              r_rx_valid <= 1'b1;
            end else begin
              // Next bit goes out on the falling edge so MOSI is stable across the rise.
              r_mosi  <= r_tx_sh[6];
              r_tx_sh <= {r_tx_sh[5:0], 1'b0};
              r_bit   <= r_bit + 3'd1;
            end
          end
        end
        S_HOLD:  if (w_cnt_last) r_ssel <= 1'b1;
        S_GUARD: if (w_cnt_last) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign tx_ready = (r_state == S_LOAD);
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign done     = r_done;
  assign SCK      = r_sck;
  assign MOSI     = r_mosi;
  assign SSEL     = r_ssel;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a mode-0 slave model answers on MISO, monitors log bus activity,
// and each frame is checked against the bytes sent and the expected frame timing.
module tb_spi_master;

  localparam int DIV      = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int LENW     = 16;
  localparam int BYTE_CYC = 16 * DIV + 1;

  logic            clk = 1'b0;
  logic            RESET = 1'b0;
  logic            start = 1'b0;
  logic [LENW-1:0] len = '0;
  logic            busy;
  logic [7:0]      tx_data = '0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            done;
  logic            SCK;
  logic            MOSI;
  logic            MISO = 1'b0;
  logic            SSEL;

  spi_master #(.DIV(DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .LENW(LENW)) dut (
    .CLK(clk), .RESET(RESET), .start(start), .len(len), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Bus monitor and mode-0 slave model: the slave presents bit (7 - falls_in_byte) of the
  // current response byte and moves on after every SCK fall.
  logic       mosi_q[$];
  logic [7:0] rx_q[$];
  int         rxt_q[$];
  logic [7:0] resp_q[$];
  int         resp_ptr = 0, bitpos = 0;
  int         rises = 0, done_cnt = 0, done_t = 0, ssel_rises = 0, ssel_rise_t = 0;
  int         mosi_hi_chg = 0, rv_done_both = 0;
  logic       prev_sck = 1'b0, prev_mosi = 1'b0, prev_ssel = 1'b1;
  logic       loop_mode = 1'b0;
  logic [7:0] cur_resp;

  always @(negedge clk) begin
    if (!RESET) begin
      resp_ptr = resp_q.size();
      bitpos   = 0;
    end else begin
      if (SCK && !prev_sck) begin
        mosi_q.push_back(MOSI);
        rises++;
      end
      if (!SCK && prev_sck) begin
        bitpos++;
        if (bitpos == 8) begin
          bitpos = 0;
          resp_ptr++;
        end
      end
      if (SSEL) bitpos = 0;
      if (prev_sck && SCK && (MOSI != prev_mosi)) mosi_hi_chg++;
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        rxt_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_t = cyc;
      end
      if (rx_valid && done) rv_done_both++;
      if (SSEL && !prev_ssel) begin
        ssel_rises++;
        ssel_rise_t = cyc;
      end
    end
    prev_sck  = SCK;
    prev_mosi = MOSI;
    prev_ssel = SSEL;
    if (loop_mode) MISO = MOSI;
    else if (resp_ptr < resp_q.size()) begin
      cur_resp = resp_q[resp_ptr];
      MISO = cur_resp[3'(7 - bitpos)];
    end else MISO = 1'b0;
  end

  typedef struct packed {
    int              n;
    logic [2:0][7:0] tx;
    logic [2:0][7:0] resp;
    logic            loopb;
    int              stall_idx;
    logic            mid_start;
    logic [2:0][7:0] exp_rx;
  } vec_t;

  int         fr_n, fr_stall_idx;
  logic       fr_loop, fr_mid_start;
  logic [7:0] fr_tx[4], fr_resp[4], fr_exp[4];

  task automatic send_frame(input string tag);
    int base_m, base_r, base_rises, base_done, base_ssr, s_edge, t, r0;
    logic prehold, stall_bad;
    logic [7:0] got;
    base_m = mosi_q.size(); base_r = rx_q.size(); base_rises = rises;
    base_done = done_cnt; base_ssr = ssel_rises;
    for (int i = 0; i < fr_n; i++) resp_q.push_back(fr_loop ? 8'h00 : fr_resp[i]);
    loop_mode = fr_loop;
    prehold = (fr_stall_idx != 0);
    @(negedge clk);
    if (prehold) begin
      tx_data = fr_tx[0];
      tx_valid = 1'b1;
    end
    start = 1'b1; len = LENW'(fr_n); s_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0; len = LENW'($urandom);
    chk({tag, " ssel_low_after_start"}, int'(SSEL), 0);
    chk({tag, " busy_after_start"}, int'(busy), 1);
    for (int i = 0; i < fr_n; i++) begin
      if (i == fr_stall_idx) begin
        tx_valid = 1'b0;
        t = 0;
        while (!tx_ready && t < 1000) begin @(negedge clk); t++; end
        r0 = rises; stall_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!tx_ready || SCK || SSEL) stall_bad = 1'b1;
          start = fr_mid_start && (k == 3);
          len = 16'd5;
        end
        start = 1'b0;
        chk({tag, " stall_lines_held"}, int'(stall_bad), 0);
        chk({tag, " stall_no_edges"}, rises - r0, 0);
      end
      tx_data = fr_tx[i];
      tx_valid = 1'b1;
      t = 0;
      while (!tx_ready && t < 1000) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    t = 0;
    while (done_cnt == base_done && t < 2000) begin @(negedge clk); t++; end
    repeat (2 * CS_HOLD + 4) @(negedge clk);

    chk({tag, " sck_rises"}, rises - base_rises, 8 * fr_n);
    for (int i = 0; i < fr_n; i++) begin
      got = 8'h00;
      for (int b = 0; b < 8; b++)
        if (base_m + 8 * i + b < mosi_q.size()) got = {got[6:0], mosi_q[base_m + 8 * i + b]};
      chk($sformatf("%s mosi_byte%0d", tag, i), int'(got), int'(fr_tx[i]));
    end
    chk({tag, " rx_count"}, rx_q.size() - base_r, fr_n);
    for (int i = 0; i < fr_n; i++)
      chk($sformatf("%s rx_byte%0d", tag, i),
          (base_r + i < rx_q.size()) ? int'(rx_q[base_r + i]) : -1, int'(fr_exp[i]));
    chk({tag, " done_count"}, done_cnt - base_done, 1);
    chk({tag, " ssel_one_rise"}, ssel_rises - base_ssr, 1);
    if (rx_q.size() >= base_r + fr_n) begin
      chk({tag, " done_after_rx"}, done_t - rxt_q[base_r + fr_n - 1], 2 * CS_HOLD);
      chk({tag, " ssel_high_after_rx"}, ssel_rise_t - rxt_q[base_r + fr_n - 1], CS_HOLD);
      if (prehold)
        chk({tag, " first_rx_latency"}, rxt_q[base_r] - s_edge, CS_SETUP + 1 + 16 * DIV);
      if (fr_stall_idx < 0)
        for (int i = 1; i < fr_n; i++)
          chk($sformatf("%s rx_spacing%0d", tag, i),
              rxt_q[base_r + i] - rxt_q[base_r + i - 1], BYTE_CYC);
    end
    $display("frame %s: len=%0d loop=%0d rx_seen=%0d", tag, fr_n, fr_loop, rx_q.size() - base_r);
  endtask

  task automatic load_vec(input vec_t v);
    fr_n = v.n; fr_loop = v.loopb; fr_stall_idx = v.stall_idx; fr_mid_start = v.mid_start;
    for (int i = 0; i < 3; i++) begin
      fr_tx[i] = v.tx[i]; fr_resp[i] = v.resp[i]; fr_exp[i] = v.exp_rx[i];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[3];
    logic bad;
    int base_done;

    vecs[0] = '{n: 1, tx: {8'h00, 8'h00, 8'hA5}, resp: {8'h00, 8'h00, 8'h3C}, loopb: 1'b0,
                stall_idx: -1, mid_start: 1'b0, exp_rx: {8'h00, 8'h00, 8'h3C}};
    vecs[1] = '{n: 3, tx: {8'h80, 8'hFF, 8'h01}, resp: {8'h00, 8'h00, 8'h00}, loopb: 1'b1,
                stall_idx: -1, mid_start: 1'b0, exp_rx: {8'h80, 8'hFF, 8'h01}};
    vecs[2] = '{n: 2, tx: {8'h00, 8'h0F, 8'h96}, resp: {8'h00, 8'hC3, 8'h55}, loopb: 1'b0,
                stall_idx: 1, mid_start: 1'b1, exp_rx: {8'h00, 8'hC3, 8'h55}};

    // Reset with random inputs applied.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'($urandom); len = LENW'($urandom); tx_data = 8'($urandom); tx_valid = 1'($urandom);
    end
    chk("reset SSEL", int'(SSEL), 1);
    chk("reset SCK", int'(SCK), 0);
    chk("reset MOSI", int'(MOSI), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset tx_ready", int'(tx_ready), 0);
    chk("reset rx_valid", int'(rx_valid), 0);
    chk("reset done", int'(done), 0);
    chk("reset rx_data", int'(rx_data), 0);
    start = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!SSEL || SCK || MOSI || busy || tx_ready || rx_valid || done || rx_data != 8'h00) bad = 1'b1;
    end
    chk("idle_after_release", int'(bad), 0);

    for (int v = 0; v < 3; v++) begin
      load_vec(vecs[v]);
      send_frame($sformatf("vec%0d", v));
    end

    // len=0 request must be ignored.
    base_done = done_cnt;
    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy || !SSEL) bad = 1'b1;
      @(negedge clk);
    end
    chk("len0_ignored", int'(bad), 0);
    chk("len0_no_done", done_cnt - base_done, 0);

    // Randomised frames against the reference: rx equals the slave's responses (or tx on loopback).
    for (int r = 0; r < 6; r++) begin
      fr_n = $urandom_range(1, 3); fr_loop = 1'($urandom); fr_stall_idx = -1; fr_mid_start = 1'b0;
      for (int i = 0; i < fr_n; i++) begin
        fr_tx[i] = 8'($urandom); fr_resp[i] = 8'($urandom);
        fr_exp[i] = fr_loop ? fr_tx[i] : fr_resp[i];
      end
      send_frame($sformatf("rnd%0d", r));
    end

    // Asynchronous reset after the fourth SCK rise of a byte.
    begin
      int r0, t;
      loop_mode = 1'b1;
      resp_q.push_back(8'h00);
      r0 = rises;
      @(negedge clk);
      tx_data = 8'h33; tx_valid = 1'b1; start = 1'b1; len = 16'd1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while ((rises - r0) < 4 && t < 500) begin @(negedge clk); t++; end
      chk("midbyte reached_rise4", rises - r0, 4);
      #1 RESET = 1'b0;
      #1;
      chk("midbyte SSEL", int'(SSEL), 1);
      chk("midbyte SCK", int'(SCK), 0);
      chk("midbyte busy", int'(busy), 0);
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      RESET = 1'b1;
      repeat (2) @(negedge clk);
    end
    fr_n = 1; fr_loop = 1'b1; fr_stall_idx = -1; fr_mid_start = 1'b0;
    fr_tx[0] = 8'h5A; fr_exp[0] = 8'h5A; fr_resp[0] = 8'h00;
    send_frame("after_reset");

    chk("mosi_stable_while_sck_high", mosi_hi_chg, 0);
    chk("rx_valid_done_never_together", rv_done_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master that streams 8-bit pixels out on MOSI and captures the 8-bit responses returned on MISO. It drives the FPGA-side SPI slave/conv pipeline from a test or host harness in the same design. Each frame is one SSEL-low window of `len` bytes. The responses are pipelined on the slave side and are returned to the user unmodified, one per transmitted byte.

## Interface
- `DIV`, 4: SCK half-period in CLK cycles; legal range ≥4, so the slave's 3-flop synchronizers see every edge.
- `CS_SETUP`, 4: CLK cycles SSEL is low before the first byte slot opens.
- `CS_HOLD`, 4: CLK cycles SSEL stays low after the last SCK fall, and also the minimum SSEL-high guard time after the frame.
- `LENW`, 16: width of the byte-count input.
- `CLK` input 1: system clock; all logic on its rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a frame; sampled only in IDLE.
- `len` input LENW: bytes in the frame; sampled together with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until return to IDLE.
- `tx_data` input 8: byte to send, MSB first.
- `tx_valid` input 1 / `tx_ready` output 1: valid/ready handshake; transfer occurs when both are high on a CLK edge.
- `rx_data` output 8: last received byte; holds its value until the next byte completes.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `done` output 1: one-cycle pulse at the end of the frame.
- `SCK` output 1, `MOSI` output 1, `MISO` input 1, `SSEL` output 1 (active low): SPI bus.

## Operation
- Reset values: SCK=0, MOSI=0, SSEL=1, busy=0, tx_ready=0, rx_valid=0, rx_data=0x00, done=0. Reset applies immediately, including mid-byte; there is no partial-byte recovery.
- States: IDLE → SETUP → LOAD → LOW → HIGH → (LOAD | HOLD) → GUARD → IDLE.
- IDLE:
  - `start`=1 with `len`≠0: latch `len` into the remaining-byte counter, go to SETUP.
  - `start` with `len`=0: ignored.
  - `start` in any other state: ignored.
- SETUP: SSEL=0, SCK=0, MOSI=0 for CS_SETUP cycles, then LOAD.
- LOAD:
  - tx_ready=1, SCK=0, MOSI=0.
  - Waits indefinitely for `tx_valid`; the stall is legal and SSEL stays low.
  - On handshake: load the shift register, set MOSI=tx_data[7], clear bit counter, decrement the remaining count, go to LOW.
- LOW: SCK=0 for DIV cycles, then go to HIGH and drive SCK=1. MISO is sampled into the rx shift register on that same edge.
- HIGH:
  - SCK=1 for DIV cycles.
  - After bits 0–6: SCK=0, MOSI advances to the next bit on the same edge, back to LOW.
  - After bit 7: SCK=0, MOSI=0, rx_data ← rx shift register, rx_valid=1 for one cycle.
  - Then LOAD if remaining ≠0, else HOLD.
- HOLD: SSEL=0, SCK=0 for CS_HOLD cycles, then SSEL=1 and go to GUARD.
- GUARD: SSEL=1 for CS_HOLD cycles; on the exit edge done=1 (one cycle), busy=0, go to IDLE.
- Bit order: MSB first both directions. MOSI only changes while SCK is low (mode 0: CPOL=0, CPHA=0).
- The remaining-byte counter is LENW bits; `len`=2^LENW−1 must complete without wrap.

## Timing
- Handshake accepted at edge t:
  - MOSI=bit7 from t+1.
  - SCK rising edges at t+1+DIV+2k·DIV, k=0..7.
  - Final SCK fall and rx_valid at t+1+16·DIV.
  - tx_ready re-asserts in that same cycle.
- Back-to-back bytes (tx_valid held high): byte period 16·DIV+1 cycles.
- `start` at edge s: SSEL=0 from s+1. The first tx_ready is at s+1+CS_SETUP.
- Last rx_valid at edge e:
  - SSEL=1 from e+CS_HOLD.
  - done pulses at e+2·CS_HOLD.
  - A new `start` is accepted from the following cycle.
- The rx_valid and tx_ready pulses coinciding in one cycle is normal. Simultaneous rx_valid and done cannot occur.

## Test plan
- Reset:
  - Stimulus: assert RESET=0 with random inputs.
  - Required: SSEL=1, SCK=0, MOSI=0, busy=0, tx_ready=0, rx_valid=0, done=0, rx_data=0x00.
  - Release RESET and hold 20 cycles: no change.
- Single byte, DIV=4:
  - Stimulus: len=1, tx 0xA5, MISO model returns 0x3C (mode 0).
  - Required: MOSI samples at SCK rises are 1,0,1,0,0,1,0,1; exactly 8 SCK rises; rx_data=0x3C with one rx_valid pulse; done 2·CS_HOLD cycles after rx_valid.
- Loopback:
  - Stimulus: MISO tied to MOSI, len=3, bytes 0x01, 0xFF, 0x80 with tx_valid held high.
  - Required: rx sequence 0x01, 0xFF, 0x80; 24 SCK rises; rx_valid pulses spaced exactly 65 cycles; SSEL low continuously.
- Stall:
  - Stimulus: deassert tx_valid for 10 cycles between bytes 1 and 2.
  - Required: SCK stays low, SSEL stays low, tx_ready stays high throughout; no extra edges; byte 2 is transferred correctly.
- Ignored starts:
  - Stimulus: `start` pulsed mid-frame; `start` with len=0 in IDLE.
  - Required: the frame is unaffected, no second done, busy stays 0 for the len=0 request.
- Async reset mid-byte:
  - Stimulus: RESET=0 after SCK rise 4 of a byte.
  - Required: SSEL=1 and SCK=0 before the next CLK edge; after release, a fresh len=1 frame sending 0x5A completes with correct rx.
